// File: rtl/mem32_access_ctrl.sv
// Load/store sequencer between the MEM stage and a 4-bank byte-lane 32-bit data memory.
// Issues word-aligned accesses only; sub-word stores are done as read-modify-write.
module mem32_access_ctrl #(
  parameter int RD_LAT = 1,
  parameter int MEM_AW = 16
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam int CntW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} ctrlStateT;

  ctrlStateT       state, stateNext;
  logic [CntW-1:0] latCnt;
  logic            weQ;
  logic [2:0]      funct3Q;
  logic [1:0]      addrLowQ;
  logic [15:0]     wdataQ;

  logic            illegal, misaligned, outOfRange, reqErr, isSw, rdLast;
  logic [7:0]      byteSel;
  logic [15:0]     halfSel;
  logic [31:0]     loadData, storeWord;

  // Request checks, evaluated on the live request in IDLE.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000:  ;
      3'b001:  misaligned = req_addr[0];
      3'b010:  misaligned = (req_addr[1:0] != 2'b00);
      3'b100:  illegal    = req_we;
      3'b101: begin
        illegal    = req_we;
        misaligned = req_addr[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign outOfRange = |req_addr[31:MEM_AW];
  assign reqErr     = illegal | misaligned | outOfRange;
  assign isSw       = req_we && (req_funct3 == 3'b010);
  assign rdLast     = (latCnt == CntW'(RD_LAT));

  // Lane extraction and sub-word merge from the aligned read word.
  assign byteSel = mem_rdata[{addrLowQ, 3'b000} +: 8];
  assign halfSel = mem_rdata[{addrLowQ[1], 4'b0000} +: 16];

  always_comb begin
    loadData = mem_rdata;
    case (funct3Q)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = mem_rdata;
    endcase
  end

  always_comb begin
    storeWord = mem_rdata;
    if (funct3Q[1:0] == 2'b00) storeWord[{addrLowQ, 3'b000} +: 8] = wdataQ[7:0];
    else                       storeWord[{addrLowQ[1], 4'b0000} +: 16] = wdataQ;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (reqErr)    stateNext = DONE;
          else if (isSw) stateNext = WR;
          else           stateNext = RD;
        end
      end
      RD:      if (rdLast) stateNext = weQ ? WR : DONE;
      WR: begin
        // Decoded from state so an async reset removes the write strobe at once.
        mem_wr    = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      latCnt    <= '0;
      weQ       <= 1'b0;
      funct3Q   <= 3'b000;
      addrLowQ  <= 2'b00;
      wdataQ    <= 16'd0;
      mem_raddr <= 32'd0;
      mem_waddr <= 32'd0;
      mem_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          weQ       <= req_we;
          funct3Q   <= req_funct3;
          addrLowQ  <= req_addr[1:0];
          wdataQ    <= req_wdata[15:0];
          mem_raddr <= {req_addr[31:2], 2'b00};
          mem_waddr <= {req_addr[31:2], 2'b00};
          latCnt    <= '0;
          if (reqErr) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
          end else if (isSw) begin
            mem_wdata <= req_wdata;
          end
        end
        RD: begin
          latCnt <= latCnt + 1'b1;
          if (rdLast) begin
            if (weQ) begin
              mem_wdata <= storeWord;
            end else begin
              rsp_rdata <= loadData;
              rsp_err   <= 1'b0;
            end
          end
        end
        WR: begin
          rsp_rdata <= 32'd0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
